pll_lock_ctrl: RTL

Acquisition and lock sequencer for the all-digital PLL. It sits between the PFD and the loop filter. It consumes the PFD's per-cycle signed error stream and sample strobe. It sequences loop-filter reset, then coarse acquisition, then fine tracking. It declares and monitors lock from windowed error statistics, and supplies the loop-filter gain select and a system-visible lock flag.

---
 rtl/pll_lock_ctrl_if.sv | 22 ++
 rtl/pll_lock_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl_if.sv
// Control/status bundle between the PLL lock sequencer and its surroundings
// (PFD error stream in, loop-filter control and lock status out).
interface pll_lock_ctrl_if;
  logic              enable;
  logic signed [3:0] error_in;
  logic              sample_en;
  logic              loop_rst;
  logic [1:0]        gain_sel;
  logic              locked;
  logic              lock_lost;
  logic [2:0]        state_o;

  modport master (
    output enable, error_in, sample_en,
    input  loop_rst, gain_sel, locked, lock_lost, state_o
  );

  modport slave (
    input  enable, error_in, sample_en,
    output loop_rst, gain_sel, locked, lock_lost, state_o
  );
endinterface

// File: rtl/pll_lock_ctrl.sv
// Acquisition and lock sequencer for the all-digital PLL: loop-filter reset, coarse
// acquisition, fine tracking, and lock declaration/monitoring from windowed error counts.
module pll_lock_ctrl #(
  parameter int unsigned WIN_LEN     = 1024,
  parameter int unsigned ERR_THRESH  = 8,
  parameter int unsigned LOCK_WINS   = 4,
  parameter int unsigned UNLOCK_WINS = 2,
  parameter int unsigned RST_CYCLES  = 16
) (
  input  logic           sys_clk,
  input  logic           rst,
  pll_lock_ctrl_if.slave bus
);

  localparam int unsigned WW = $clog2(WIN_LEN);
  localparam int unsigned EW = $clog2(ERR_THRESH + 2);
  localparam int unsigned QW = $clog2(LOCK_WINS + 1);
  localparam int unsigned NW = $clog2(UNLOCK_WINS + 1);
  localparam int unsigned RW = $clog2(RST_CYCLES + 1);

  localparam logic [WW-1:0] WCNT_LAST = WW'(WIN_LEN - 1);
  localparam logic [EW-1:0] ECNT_SAT  = EW'(ERR_THRESH + 1);
  localparam logic [EW-1:0] ECNT_LIM  = EW'(ERR_THRESH);
  localparam logic [QW-1:0] QCNT_LOCK = QW'(LOCK_WINS);
  localparam logic [NW-1:0] NCNT_DROP = NW'(UNLOCK_WINS);
  localparam logic [RW-1:0] RCNT_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOP_RST = 3'd1,
    S_ACQUIRE  = 3'd2,
    S_TRACK    = 3'd3,
    S_LOCKED   = 3'd4
  } state_e;

  state_e        state_q,     state_d;
  logic [WW-1:0] wcnt_q,      wcnt_d;
  logic [EW-1:0] ecnt_q,      ecnt_d;
  logic [QW-1:0] qcnt_q,      qcnt_d;
  logic [NW-1:0] ncnt_q,      ncnt_d;
  logic [RW-1:0] rcnt_q,      rcnt_d;
  logic          lock_lost_q, lock_lost_d;

  logic [EW-1:0] ecnt_inc;
  logic          win_active;
  logic          win_end;
  logic          quiet;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ecnt_d      = ecnt_q;
    qcnt_d      = qcnt_q;
    ncnt_d      = ncnt_q;
    rcnt_d      = rcnt_q;
    lock_lost_d = 1'b0;
    win_end     = 1'b0;
    quiet       = 1'b0;
    win_active  = state_q inside {S_ACQUIRE, S_TRACK, S_LOCKED};

    // Error count including the current sample; saturates one above the threshold.
    ecnt_inc = ecnt_q;
    if ((|bus.error_in) && (ecnt_q != ECNT_SAT)) ecnt_inc = ecnt_q + 1'b1;

    if (win_active && bus.sample_en) begin
      if (wcnt_q == WCNT_LAST) begin
        win_end = 1'b1;
        quiet   = (ecnt_inc <= ECNT_LIM);
        wcnt_d  = '0;
        ecnt_d  = '0;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
        ecnt_d = ecnt_inc;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_LOOP_RST;
      end
      S_LOOP_RST: begin
        if (rcnt_q == RCNT_LAST) state_d = S_ACQUIRE;
        else                     rcnt_d  = rcnt_q + 1'b1;
      end
      S_ACQUIRE: begin
        if (win_end && quiet) state_d = S_TRACK;
      end
      S_TRACK: begin
        if (win_end) begin
          if (quiet) begin
            qcnt_d = qcnt_q + 1'b1;
            if (qcnt_d == QCNT_LOCK) state_d = S_LOCKED;
          end else begin
            state_d = S_ACQUIRE;
          end
        end
      end
      S_LOCKED: begin
        if (win_end) begin
          if (quiet) begin
            ncnt_d = '0;
          end else begin
            ncnt_d = ncnt_q + 1'b1;
            if (ncnt_d == NCNT_DROP) begin
              state_d     = S_ACQUIRE;
              lock_lost_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable wins over any window outcome and is not a loss of lock.
    if ((state_q != S_IDLE) && !bus.enable) begin
      state_d     = S_IDLE;
      lock_lost_d = 1'b0;
    end

    if (state_d != state_q) begin
      wcnt_d = '0;
      ecnt_d = '0;
      qcnt_d = '0;
      ncnt_d = '0;
      rcnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      ecnt_q      <= '0;
      qcnt_q      <= '0;
      ncnt_q      <= '0;
      rcnt_q      <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ecnt_q      <= ecnt_d;
      qcnt_q      <= qcnt_d;
      ncnt_q      <= ncnt_d;
      rcnt_q      <= rcnt_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Moore decode; unused encodings look like IDLE for the one cycle they last.
  always_comb begin
    bus.loop_rst = 1'b1;
    bus.gain_sel = 2'd2;
    bus.locked   = 1'b0;
    case (state_q)
      S_ACQUIRE: begin
        bus.loop_rst = 1'b0;
        bus.gain_sel = 2'd2;
      end
      S_TRACK: begin
        bus.loop_rst = 1'b0;
        bus.gain_sel = 2'd1;
      end
      S_LOCKED: begin
        bus.loop_rst = 1'b0;
        bus.gain_sel = 2'd0;
        bus.locked   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.lock_lost = lock_lost_q;
  assign bus.state_o   = state_q;

endmodule
